// File: rtl/ex_mc_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, the branch opcode,
// the control FSM state type and bit positions inside the {N,Z,V} flag vector.
package ex_mc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_PASS = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;

  localparam logic [3:0] OPC_B = 4'hC;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, DATA_W
// iterations, low DATA_W bits of the product. Present only when EX_MUL_EN is
// defined; without it this file contributes no module.
`ifdef EX_MUL_EN
module ex_mul_iter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] partial;

  // One shift-add step per cycle; the down-counter marks remaining iterations.
  always_comb begin
    partial  = mplier_q[0] ? mcand_q : '0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      acc_d    = '0;
      mcand_d  = op_a;
      mplier_d = op_b;
      cnt_d    = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  // Terminal count: the last iteration is in flight, so the final sum is
  // offered combinationally and the caller captures it on this edge.
  always_comb begin
    done    = (cnt_q == CNT_W'(1));
    product = acc_q + partial;
  end

  // Multiplier registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/ex_mc.sv
// Execute stage: single-cycle ALU with a one-entry registered output and
// valid/ready handshakes on both sides. With EX_MUL_EN defined, MUL runs on
// the iterative multiplier ex_mul_iter under a two-state FSM.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | can accept work (when output slot free or draining)
//   ST_MUL  | multiplier iterating; no issue accepted, busy high
module ex_mc
  import ex_mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SH_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [DATA_W-1:0] sext_in,
  input  logic [15:0]       instr,
  input  logic              alu_src,
  input  logic [3:0]        alu_op,
  input  logic [SH_W-1:0]   sh_amt,
  input  logic [2:0]        flags_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] target_addr,
  output logic [2:0]        flags,
  input  logic              flush,
  output logic              busy
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [2:0]        flags_q, flags_d;

  logic [DATA_W-1:0] op0, op1;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        alu_flags;
  logic              alu_upd, alu_v;
  logic              accept;
  logic              instr_unused;

  assign instr_unused = ^instr[11:9];

  // Branches compute pc+1 plus the 9-bit offset; everything else uses registers.
  always_comb begin
    if (instr[15:12] == OPC_B) begin
      op0 = pc + DATA_W'(1);
      op1 = {{(DATA_W-9){instr[8]}}, instr[8:0]};
    end else begin
      op0 = reg1;
      op1 = alu_src ? reg2 : sext_in;
    end
  end

  // Single-cycle ALU; only arithmetic/logic ops replace the incoming flags.
  always_comb begin
    alu_res   = '0;
    alu_upd   = 1'b0;
    alu_v     = 1'b0;
    alu_flags = flags_in;
    case (alu_op)
      ALU_ADD: begin
        alu_res = op0 + op1;
        alu_upd = 1'b1;
        alu_v   = (op0[DATA_W-1] == op1[DATA_W-1]) && (alu_res[DATA_W-1] != op0[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res = op0 - op1;
        alu_upd = 1'b1;
        alu_v   = (op0[DATA_W-1] != op1[DATA_W-1]) && (alu_res[DATA_W-1] != op0[DATA_W-1]);
      end
      ALU_AND: begin alu_res = op0 & op1; alu_upd = 1'b1; end
      ALU_OR:  begin alu_res = op0 | op1; alu_upd = 1'b1; end
      ALU_XOR: begin alu_res = op0 ^ op1; alu_upd = 1'b1; end
      ALU_SLL:  alu_res = op0 << sh_amt;
      ALU_SRL:  alu_res = op0 >> sh_amt;
      ALU_SRA:  alu_res = $signed(op0) >>> sh_amt;
      ALU_PASS: alu_res = op0;
      default:  alu_res = '0;
    endcase
    if (alu_upd) begin
      alu_flags[FLAG_N] = alu_res[DATA_W-1];
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_V] = alu_v;
    end
  end

`ifdef EX_MUL_EN
  ex_state_e         state_q, state_d;
  logic [2:0]        mul_flags_q, mul_flags_d;
  logic              mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;

  ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (flush),
    .op_a    (op0),
    .op_b    (op1),
    .done    (mul_done),
    .product (mul_product)
  );

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign busy     = (state_q == ST_MUL);
`else
  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  // Output slot / FSM next state: flush wins over accept, drain and reload share a cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
`ifdef EX_MUL_EN
    state_d     = state_q;
    mul_flags_d = mul_flags_q;
    mul_start   = 1'b0;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) begin
      out_valid_d = 1'b0;
`ifdef EX_MUL_EN
      state_d     = ST_IDLE;
`endif
    end
`ifdef EX_MUL_EN
    else if (accept && (alu_op == ALU_MUL)) begin
      state_d     = ST_MUL;
      mul_start   = 1'b1;
      mul_flags_d = flags_in;
    end else if ((state_q == ST_MUL) && mul_done) begin
      state_d     = ST_IDLE;
      result_d    = mul_product;
      flags_d     = mul_flags_q;
      out_valid_d = 1'b1;
    end
`endif
    else if (accept) begin
      result_d    = alu_res;
      flags_d     = alu_flags;
      out_valid_d = 1'b1;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

`ifdef EX_MUL_EN
  // FSM state and the flags captured when a MUL is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mul_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_flags_q <= mul_flags_d;
    end
  end
`endif

  assign out_valid   = out_valid_q;
  assign alu_result  = result_q;
  assign target_addr = result_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_ex_mc.sv
// Self-checking bench for ex_mc: scoreboard of expected {flags,result}
// pushed at issue and popped when the consumer takes an output, plus directed
// checks on reset, latency, backpressure, flush and (with EX_MUL_EN) MUL.
module tb_ex_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] pc = '0, reg1 = '0, reg2 = '0, sext_in = '0;
  logic [15:0] instr = '0;
  logic        alu_src = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [3:0]  sh_amt = '0;
  logic [2:0]  flags_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] alu_result, target_addr;
  logic [2:0]  flags;
  logic        flush = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] sb[$];

  always #5 clk = ~clk;

  ex_mc #(.DATA_W(16), .SH_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .reg1(reg1), .reg2(reg2), .sext_in(sext_in), .instr(instr),
    .alu_src(alu_src), .alu_op(alu_op), .sh_amt(sh_amt), .flags_in(flags_in),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .target_addr(target_addr), .flags(flags), .flush(flush), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model over the currently driven inputs: {flags, result}.
  function automatic logic [18:0] model_now();
    logic [15:0] a, b, r;
    logic [2:0]  f;
    int          sa, sbv, s;
    bit          upd, v;
    upd = 0; v = 0; r = '0; f = flags_in;
    if (instr[15:12] == 4'hC) begin
      a = pc + 16'd1;
      b = {{7{instr[8]}}, instr[8:0]};
    end else begin
      a = reg1;
      b = alu_src ? reg2 : sext_in;
    end
    sa = int'($signed(a));
    sbv = int'($signed(b));
    case (alu_op)
      4'd0: begin s = sa + sbv; r = a + b; v = (s > 32767) || (s < -32768); upd = 1; end
      4'd1: begin s = sa - sbv; r = a - b; v = (s > 32767) || (s < -32768); upd = 1; end
      4'd2: begin r = a & b; upd = 1; end
      4'd3: begin r = a | b; upd = 1; end
      4'd4: begin r = a ^ b; upd = 1; end
      4'd5: r = a << sh_amt;
      4'd6: r = a >> sh_amt;
      4'd7: r = 16'(sa >>> sh_amt);
      4'd8: r = a;
`ifdef EX_MUL_EN
      4'd9: r = 16'(a * b);
`endif
      default: r = '0;
    endcase
    if (upd) f = {r[15], (r == 16'd0), v};
    return {f, r};
  endfunction

  task automatic set_in(input logic [3:0] op, input logic [15:0] r1, input logic [15:0] r2,
                        input logic [15:0] sx, input logic src, input logic [3:0] sh,
                        input logic [2:0] fi);
    alu_op = op; reg1 = r1; reg2 = r2; sext_in = sx; alu_src = src;
    sh_amt = sh; flags_in = fi; instr = 16'h0000; pc = 16'h0000;
  endtask

  // Raise in_valid, wait (bounded) for the handshake, optionally log expectation.
  task automatic accept_one(input bit push);
    in_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 64 && in_ready !== 1'b1; k++) @(negedge clk);
    chk("accept_timeout", 64'(in_ready), 64'(1));
    if (in_ready === 1'b1 && push) sb.push_back(model_now());
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Consumer side: every output taken must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      assert (sb.size() > 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected: observed result %0h with nothing expected", alu_result);
      end
      if (sb.size() > 0) begin
        logic [18:0] e;
        e = sb.pop_front();
        chk("sb_out", 64'({flags, alu_result, target_addr}), 64'({e[18:16], e[15:0], e[15:0]}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_result", 64'(alu_result), 64'(0));
    chk("rst_target", 64'(target_addr), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // ADD overflow, latency 1
    set_in(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b1, 4'd0, 3'b000);
    accept_one(1);
    @(negedge clk);
    chk("add_valid", 64'(out_valid), 64'(1));
    chk("add_result", 64'(alu_result), 64'h8000);
    chk("add_flags", 64'(flags), 64'(3'b101));
    @(posedge clk); #1;

    // Branch target
    set_in(4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 4'd0, 3'b000);
    pc = 16'h0010; instr = 16'hC1FE;
    accept_one(1);
    @(negedge clk);
    chk("br_target", 64'(target_addr), 64'h000F);
    @(posedge clk); #1;

    // Back-to-back op mix
    set_in(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 4'd0, 3'b101); accept_one(1);
    set_in(4'd1, 16'h8000, 16'h0001, 16'h0000, 1'b1, 4'd0, 3'b000); accept_one(1);
    set_in(4'd2, 16'hF0F0, 16'h0000, 16'h0FF0, 1'b0, 4'd0, 3'b111); accept_one(1);
    set_in(4'd3, 16'h1200, 16'h0034, 16'h0000, 1'b1, 4'd0, 3'b000); accept_one(1);
    set_in(4'd4, 16'hFFFF, 16'h8001, 16'h0000, 1'b1, 4'd0, 3'b000); accept_one(1);
    set_in(4'd5, 16'h0001, 16'h0000, 16'h0000, 1'b1, 4'd15, 3'b011); accept_one(1);
    set_in(4'd6, 16'h8000, 16'h0000, 16'h0000, 1'b1, 4'd3, 3'b010); accept_one(1);
    set_in(4'd8, 16'hBEEF, 16'h1111, 16'h0000, 1'b1, 4'd0, 3'b110); accept_one(1);
    set_in(4'hF, 16'h1234, 16'h5678, 16'h0000, 1'b1, 4'd0, 3'b011); accept_one(1);
    set_in(4'd7, 16'h8000, 16'h0000, 16'h0000, 1'b1, 4'd3, 3'b101); accept_one(1);
    @(negedge clk);
    chk("sra_result", 64'(alu_result), 64'hF000);
    chk("sra_flags", 64'(flags), 64'(3'b101));
    @(posedge clk); #1;

    // Backpressure then simultaneous drain + accept
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    set_in(4'd8, 16'h1234, 16'h0000, 16'h0000, 1'b1, 4'd0, 3'b001); accept_one(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_result", 64'(alu_result), 64'h1234);
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    set_in(4'd0, 16'h0100, 16'h0023, 16'h0000, 1'b1, 4'd0, 3'b000);
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 64'(in_ready), 64'(1));
    if (in_ready === 1'b1) sb.push_back(model_now());
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 64'(out_valid), 64'(1));
    chk("b2b_result", 64'(alu_result), 64'h0123);
    @(posedge clk); #1;

    // Flush overrides a simultaneous accept
    repeat (2) @(posedge clk); #1;
    set_in(4'd0, 16'h0001, 16'h0001, 16'h0000, 1'b1, 4'd0, 3'b000);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;

    // Flush drops a held result
    out_ready = 1'b0;
    set_in(4'd8, 16'hAAAA, 16'h0000, 16'h0000, 1'b1, 4'd0, 3'b000); accept_one(0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_held_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;

`ifdef EX_MUL_EN
    // MUL: 16 busy cycles, output on the 17th
    set_in(4'd9, 16'h0003, 16'h0005, 16'h0000, 1'b1, 4'd0, 3'b010); accept_one(1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("mul_busy", 64'(busy), 64'(1));
      chk("mul_in_ready", 64'(in_ready), 64'(0));
      chk("mul_no_valid", 64'(out_valid), 64'(0));
    end
    @(negedge clk);
    chk("mul_busy_end", 64'(busy), 64'(0));
    chk("mul_valid", 64'(out_valid), 64'(1));
    chk("mul_result", 64'(alu_result), 64'h000F);
    chk("mul_flags", 64'(flags), 64'(3'b010));
    @(posedge clk); #1;

    // MUL with signed-looking operands (low bits of product)
    set_in(4'd9, 16'hFFFE, 16'h0000, 16'h0123, 1'b0, 4'd0, 3'b100); accept_one(1);
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    @(posedge clk); #1;

    // Flush during cycle 5 of a MUL
    set_in(4'd9, 16'h0007, 16'h0009, 16'h0000, 1'b1, 4'd0, 3'b000); accept_one(0);
    repeat (4) @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("mul_flush_busy_before", 64'(busy), 64'(1));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("mul_flush_busy", 64'(busy), 64'(0));
    chk("mul_flush_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    set_in(4'd0, 16'h0002, 16'h0003, 16'h0000, 1'b1, 4'd0, 3'b000); accept_one(1);
    repeat (24) @(posedge clk); #1;

    // Reset mid-MUL abandons the operation
    set_in(4'd9, 16'h0011, 16'h0011, 16'h0000, 1'b1, 4'd0, 3'b000); accept_one(0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mul_rst_busy", 64'(busy), 64'(0));
    chk("mul_rst_valid", 64'(out_valid), 64'(0));
    repeat (24) @(posedge clk); #1;
`else
    // MUL without the multiplier behaves as an undefined op
    set_in(4'd9, 16'h0003, 16'h0005, 16'h0000, 1'b1, 4'd0, 3'b010); accept_one(1);
    @(negedge clk);
    chk("mul_off_busy", 64'(busy), 64'(0));
    chk("mul_off_valid", 64'(out_valid), 64'(1));
    chk("mul_off_result", 64'(alu_result), 64'(0));
    chk("mul_off_flags", 64'(flags), 64'(3'b010));
    @(posedge clk); #1;
`endif

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_mc.md
EX_MC -- requirements
Module: ex_mc

Interface
REQ-001 Parameter: DATA_W, default 16, datapath width of operands, result and PC.
REQ-002 Parameter: SH_W, default 4, shift-amount width; SHALL equal clog2(DATA_W).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  issue request; in_ready  output  1  stage can accept.
REQ-006 Port: pc, reg1, reg2, sext_in  input  DATA_W each  PC, register operands, sign-extended immediate.
REQ-007 Port: instr  input  16  instruction; instr[15:12] opcode, instr[8:0] branch offset.
REQ-008 Port: alu_src  input  1  1 selects reg2, 0 selects sext_in as second operand.
REQ-009 Port: alu_op  input  4  operation; sh_amt  input  SH_W  shift amount; flags_in  input  3  {N,Z,V} carried in.
REQ-010 Port: out_valid  output  1  result held; out_ready  input  1  consumer accepts.
REQ-011 Port: alu_result, target_addr  output  DATA_W each; flags  output  3  {N,Z,V}.
REQ-012 Port: flush  input  1  squash in-flight and held work; busy  output  1  multi-cycle op running.

Function
REQ-013 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-014 in_ready SHALL be 1 iff state is IDLE and (out_valid is 0 or out_ready is 1).
REQ-015 Operands: op0 = pc+1 and op1 = sign-extended instr[8:0] when opcode is OPC_B; else op0 = reg1, op1 = alu_src ? reg2 : sext_in.
REQ-016 Ops: ADD, SUB, AND, OR, XOR modulo 2^DATA_W; SLL, SRL, SRA by sh_amt; PASS returns op0.
REQ-017 Single-cycle ops: registered outputs valid on the cycle after acceptance (latency 1).
REQ-018 FSM states IDLE, MUL; IDLE->MUL on accepted MUL; MUL->IDLE after exactly DATA_W iterations.
REQ-019 MUL: shift-add over DATA_W cycles; result is low DATA_W bits of op0*op1; out_valid rises on cycle DATA_W+1 after acceptance.
REQ-020 busy SHALL be 1 exactly while state is MUL.
REQ-021 Flags: Z = (result == 0), N = result MSB, V = signed overflow for ADD/SUB only.
REQ-022 Only ADD, SUB, AND, OR, XOR update all three flags; all other ops output flags_in unchanged.
REQ-023 target_addr SHALL equal alu_result.
REQ-024 Held result SHALL remain stable while out_valid && !out_ready.
REQ-025 Simultaneous drain and accept: output register reloads the same cycle; no bubble.
REQ-026 flush: out_valid -> 0 and state -> IDLE next cycle; flush overrides a simultaneous accept.
REQ-027 Undefined alu_op encodings: result 0, flags = flags_in, latency 1.

Reset
REQ-028 On rst: state IDLE, out_valid 0, busy 0, alu_result 0, target_addr 0, flags 0, multiplier registers 0.
REQ-029 rst mid-MUL SHALL abandon the operation with no output produced.
REQ-030 rst SHALL take priority over flush and all handshakes.

Configuration
REQ-031 Macro EX_MUL_EN: when defined, MUL and the MUL state exist per REQ-018/019.
REQ-032 Without EX_MUL_EN: MUL handled as an undefined op (REQ-027); busy tied 0; no MUL state logic.

Structure
REQ-033 Shared package holds ALU_ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, PASS=8, MUL=9, OPC_B=4'hC, the FSM state type and flag bit indices.
REQ-034 One sub-module, ex_mul_iter, holds the iterative multiplier (start, done, operands, product); all else in ex_mc.

Verification
REQ-035 ADD reg1=0x7FFF, reg2=0x0001, alu_src=1 -> next cycle alu_result=0x8000, flags N=1 Z=0 V=1.
REQ-036 OPC_B, pc=0x0010, instr[8:0]=0x1FE -> alu_result=target_addr=0x000F.
REQ-037 MUL 0x0003 x 0x0005 (EX_MUL_EN) -> busy for 16 cycles, in_ready 0 meanwhile, alu_result=0x000F, flags=flags_in.
REQ-038 out_ready held 0 for 3 cycles after result 0x1234 -> result stable, in_ready 0; out_ready=1 with in_valid=1 -> back-to-back transfer.
REQ-039 flush on cycle 5 of a MUL -> busy 0 and out_valid 0 next cycle; following ADD completes normally.
REQ-040 SRA reg1=0x8000, sh_amt=3 -> alu_result=0xF000, flags=flags_in=3'b101.
